tchk_window_monitor: RTL and testbench

Cycle-based setup/hold window checker for a WIDTH-bit data vector against a strobe. Everything is sampled on a single fast clock `clk`. It generalises a fixed single-window `$setup` check into a synthesizable, parametrised monitor. The monitor has per-bit data ages, a hold window, violation pulses, offending-bit reporting and saturating violation counters. It sits beside a DUT interface in benches, or in silicon debug logic, and observes only; it never drives the checked signals.

---
 rtl/tchk_window_monitor.sv | 159 +++++++++++++++
 tb/tb_tchk_window_monitor.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tchk_window_monitor.sv
// Cycle-based setup/hold window monitor: tracks per-bit data ages and the age of the
// last strobe edge, and reports setup/hold violations with pulses, bit masks and counters.
`timescale 1ns/1ps
module tchk_window_monitor #(
    parameter int WIDTH = 8,
    parameter int SETUP = 6,
    parameter int HOLD  = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_i,
    input  logic             strobe_i,
    input  logic             en_i,
    input  logic             clr_i,
    output logic             setup_viol_o,
    output logic             hold_viol_o,
    output logic [WIDTH-1:0] viol_bits_o,
    output logic [CNT_W-1:0] setup_cnt_o,
    output logic [CNT_W-1:0] hold_cnt_o,
    output logic             sticky_o
);

    localparam int AGE_MAX = (SETUP > HOLD) ? SETUP : HOLD;
    localparam int AGE_W   = $clog2(AGE_MAX + 2);
    localparam logic [AGE_W-1:0] SETUP_A  = AGE_W'(SETUP);
    localparam logic [AGE_W-1:0] HOLD_A   = AGE_W'(HOLD);
    localparam logic [AGE_W-1:0] HAGE_MAX = AGE_W'(HOLD + 1);
    localparam logic [AGE_W-1:0] AGE_ONE  = AGE_W'(1);

    logic [WIDTH-1:0] in_q, in_d;
    logic             strobe_q, strobe_d;
    logic             primed_q, primed_d;
    logic [AGE_W-1:0] age_q [WIDTH];
    logic [AGE_W-1:0] age_d [WIDTH];
    logic [AGE_W-1:0] hage_q, hage_d;
    logic             setup_viol_q, setup_viol_d;
    logic             hold_viol_q, hold_viol_d;
    logic [WIDTH-1:0] viol_bits_q, viol_bits_d;
    logic [CNT_W-1:0] setup_cnt_q, setup_cnt_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             sticky_q, sticky_d;

    logic [WIDTH-1:0] d;
    logic             sedge;
    logic [WIDTH-1:0] sbits;
    logic [WIDTH-1:0] hbits;

    // Ages saturate at SETUP / HOLD+1, which already means "far enough away to be safe".
    always_comb begin
        d            = '0;
        sedge        = 1'b0;
        sbits        = '0;
        hbits        = '0;
        in_d         = in_i;
        strobe_d     = strobe_i;
        primed_d     = 1'b1;
        age_d        = age_q;
        hage_d       = hage_q;
        setup_viol_d = 1'b0;
        hold_viol_d  = 1'b0;
        viol_bits_d  = viol_bits_q;
        setup_cnt_d  = setup_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        sticky_d     = sticky_q;

        if (primed_q) begin
            d     = in_i ^ in_q;
            sedge = strobe_i & ~strobe_q;

            for (int i = 0; i < WIDTH; i++) begin
                if (d[i]) begin
                    age_d[i] = AGE_ONE;
                end else if (age_q[i] >= SETUP_A) begin
                    age_d[i] = SETUP_A;
                end else begin
                    age_d[i] = age_q[i] + AGE_ONE;
                end
                sbits[i] = sedge && en_i && ((d[i] ? '0 : age_q[i]) < SETUP_A);
            end

            if (sedge) begin
                hage_d = AGE_ONE;
            end else if (hage_q >= HAGE_MAX) begin
                hage_d = HAGE_MAX;
            end else begin
                hage_d = hage_q + AGE_ONE;
            end

            if (en_i && !sedge && (hage_q <= HOLD_A)) begin
                hbits = d;
            end

            if (|sbits) begin
                setup_viol_d = 1'b1;
                viol_bits_d  = sbits;
                sticky_d     = 1'b1;
                if (setup_cnt_q != '1) begin
                    setup_cnt_d = setup_cnt_q + CNT_W'(1);
                end
            end

            if (|hbits) begin
                hold_viol_d = 1'b1;
                viol_bits_d = hbits;
                sticky_d    = 1'b1;
                if (hold_cnt_q != '1) begin
                    hold_cnt_d = hold_cnt_q + CNT_W'(1);
                end
            end
        end

        // Clear wins over a same-cycle increment but leaves the pulses alone.
        if (clr_i) begin
            setup_cnt_d = '0;
            hold_cnt_d  = '0;
            sticky_d    = 1'b0;
            viol_bits_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q         <= '0;
            strobe_q     <= 1'b0;
            primed_q     <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                age_q[i] <= SETUP_A;
            end
            hage_q       <= HAGE_MAX;
            setup_viol_q <= 1'b0;
            hold_viol_q  <= 1'b0;
            viol_bits_q  <= '0;
            setup_cnt_q  <= '0;
            hold_cnt_q   <= '0;
            sticky_q     <= 1'b0;
        end else begin
            in_q         <= in_d;
            strobe_q     <= strobe_d;
            primed_q     <= primed_d;
            age_q        <= age_d;
            hage_q       <= hage_d;
            setup_viol_q <= setup_viol_d;
            hold_viol_q  <= hold_viol_d;
            viol_bits_q  <= viol_bits_d;
            setup_cnt_q  <= setup_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            sticky_q     <= sticky_d;
        end
    end

    assign setup_viol_o = setup_viol_q;
    assign hold_viol_o  = hold_viol_q;
    assign viol_bits_o  = viol_bits_q;
    assign setup_cnt_o  = setup_cnt_q;
    assign hold_cnt_o   = hold_cnt_q;
    assign sticky_o     = sticky_q;

endmodule

// File: tb/tb_tchk_window_monitor.sv
// Bench for tchk_window_monitor: directed table, saturation and reset sequences, then random
// stimulus against a timestamp-based reference model; a CNT_W=2 copy shares the stimulus.
`timescale 1ns/1ps
module tb_tchk_window_monitor;

    localparam int W     = 8;
    localparam int SETUP = 6;
    localparam int HOLD  = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] inSig = 8'h01;
    logic         strobeSig = 1'b0;
    logic         enSig = 1'b1;
    logic         clrSig = 1'b0;

    logic         setupViol, holdViol, sticky;
    logic [W-1:0] violBits;
    logic [15:0]  setupCnt, holdCnt;
    logic         satSetupViol, satHoldViol, satSticky;
    logic [W-1:0] satViolBits;
    logic [1:0]   satSetupCnt, satHoldCnt;

    int vecCount  = 0;
    int missCount = 0;

    tchk_window_monitor #(.WIDTH(W), .SETUP(SETUP), .HOLD(HOLD), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .in_i(inSig), .strobe_i(strobeSig), .en_i(enSig), .clr_i(clrSig),
        .setup_viol_o(setupViol), .hold_viol_o(holdViol), .viol_bits_o(violBits),
        .setup_cnt_o(setupCnt), .hold_cnt_o(holdCnt), .sticky_o(sticky)
    );

    tchk_window_monitor #(.WIDTH(W), .SETUP(SETUP), .HOLD(HOLD), .CNT_W(2)) dutSat (
        .clk(clk), .rst(rst), .in_i(inSig), .strobe_i(strobeSig), .en_i(enSig), .clr_i(clrSig),
        .setup_viol_o(satSetupViol), .hold_viol_o(satHoldViol), .viol_bits_o(satViolBits),
        .setup_cnt_o(satSetupCnt), .hold_cnt_o(satHoldCnt), .sticky_o(satSticky)
    );

    always #5 clk = ~clk;

    // Reference model: remembers the cycle of each bit's last change and of the last strobe edge.
    int           cyc = 0;
    bit           mPrimed;
    logic [W-1:0] mPrevIn;
    logic         mPrevStr;
    int           lastChange [W];
    int           lastEdge;
    logic         mSv, mHv, mSt;
    logic [W-1:0] mBits;
    int           mSc, mHc;

    function void modelReset();
        mPrimed  = 1'b0;
        mPrevIn  = '0;
        mPrevStr = 1'b0;
        for (int i = 0; i < W; i++) lastChange[i] = -1000;
        lastEdge = -1000;
        mSv = 1'b0; mHv = 1'b0; mSt = 1'b0; mBits = '0; mSc = 0; mHc = 0;
    endfunction

    function void modelStep();
        logic [W-1:0] changed, sb, hb;
        logic         isEdge;
        cyc = cyc + 1;
        mSv = 1'b0;
        mHv = 1'b0;
        if (!mPrimed) begin
            mPrimed = 1'b1;
        end else begin
            changed = inSig ^ mPrevIn;
            isEdge  = strobeSig && !mPrevStr;
            sb = '0;
            hb = '0;
            if (isEdge && enSig) begin
                for (int i = 0; i < W; i++) begin
                    if ((changed[i] ? 0 : (cyc - lastChange[i])) < SETUP) sb[i] = 1'b1;
                end
            end
            if (!isEdge && enSig && (cyc - lastEdge) <= HOLD) hb = changed;
            for (int i = 0; i < W; i++) if (changed[i]) lastChange[i] = cyc;
            if (isEdge) lastEdge = cyc;
            if (sb != 0) begin
                mSv = 1'b1; mBits = sb; mSt = 1'b1;
                if (mSc < 65535) mSc = mSc + 1;
            end
            if (hb != 0) begin
                mHv = 1'b1; mBits = hb; mSt = 1'b1;
                if (mHc < 65535) mHc = mHc + 1;
            end
        end
        mPrevIn  = inSig;
        mPrevStr = strobeSig;
        if (clrSig) begin
            mSc = 0; mHc = 0; mSt = 1'b0; mBits = '0;
        end
    endfunction

    task automatic applyStimulus(input logic [W-1:0] inV, input logic str, input logic en,
                                 input logic clr);
        @(negedge clk);
        inSig     = inV;
        strobeSig = str;
        enSig     = en;
        clrSig    = clr;
        @(posedge clk);
        modelStep();
        #1;
    endtask

    task automatic checkOutput(input string name, input logic eSv, input logic eHv,
                               input logic [W-1:0] eBits, input int eSc, input int eHc,
                               input logic eSt);
        int eSatSc, eSatHc;
        eSatSc = (eSc > 3) ? 3 : eSc;
        eSatHc = (eHc > 3) ? 3 : eHc;
        vecCount++;
        if (setupViol !== eSv || holdViol !== eHv || violBits !== eBits ||
            setupCnt !== 16'(eSc) || holdCnt !== 16'(eHc) || sticky !== eSt ||
            satSetupViol !== eSv || satHoldViol !== eHv || satViolBits !== eBits ||
            satSetupCnt !== 2'(eSatSc) || satHoldCnt !== 2'(eSatHc) || satSticky !== eSt) begin
            missCount++;
            $display("[TB] FAIL %s: got sv=%b hv=%b bits=%h sc=%0d hc=%0d st=%b satSc=%0d satHc=%0d | required sv=%b hv=%b bits=%h sc=%0d hc=%0d st=%b satSc=%0d satHc=%0d",
                     name, setupViol, holdViol, violBits, setupCnt, holdCnt, sticky,
                     satSetupCnt, satHoldCnt, eSv, eHv, eBits, eSc, eHc, eSt, eSatSc, eSatHc);
        end
    endtask

    task automatic checkModel(input string name);
        checkOutput(name, mSv, mHv, mBits, mSc, mHc, mSt);
    endtask

    typedef struct {
        logic [W-1:0] inV;
        logic         str, en, clr;
        logic         eSv, eHv;
        logic [W-1:0] eBits;
        int           eSc, eHc;
        logic         eSt;
    } vec_t;

    vec_t vecs[$];

    function void addRow(input logic [W-1:0] inV, input logic str, input logic en,
                         input logic clr, input logic eSv, input logic eHv,
                         input logic [W-1:0] eBits, input int eSc, input int eHc,
                         input logic eSt);
        vec_t v;
        v.inV = inV; v.str = str; v.en = en; v.clr = clr;
        v.eSv = eSv; v.eHv = eHv; v.eBits = eBits; v.eSc = eSc; v.eHc = eHc; v.eSt = eSt;
        vecs.push_back(v);
    endfunction

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [W-1:0] mask;
        logic         str;

        // Directed rows: prime, setup hit (eff=3), clean setup (eff=6), coincident 0x81,
        // hold hit at +2 but not +3, en-low edge and change, then clr.
        addRow(8'h01, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        addRow(8'h01, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        for (int k = 0; k < 3; k++) addRow(8'h03, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0);
        addRow(8'h03, 1, 1, 0, 1, 0, 8'h02, 1, 0, 1);
        addRow(8'h03, 1, 1, 0, 0, 0, 8'h02, 1, 0, 1);
        addRow(8'h03, 0, 1, 0, 0, 0, 8'h02, 1, 0, 1);
        for (int k = 0; k < 6; k++) addRow(8'h07, 0, 1, 0, 0, 0, 8'h02, 1, 0, 1);
        addRow(8'h07, 1, 1, 0, 0, 0, 8'h02, 1, 0, 1);
        for (int k = 0; k < 3; k++) addRow(8'h07, 0, 1, 0, 0, 0, 8'h02, 1, 0, 1);
        addRow(8'h86, 1, 1, 0, 1, 0, 8'h81, 2, 0, 1);
        addRow(8'h86, 1, 1, 0, 0, 0, 8'h81, 2, 0, 1);
        for (int k = 0; k < 5; k++) addRow(8'h86, 0, 1, 0, 0, 0, 8'h81, 2, 0, 1);
        addRow(8'h86, 1, 1, 0, 0, 0, 8'h81, 2, 0, 1);
        addRow(8'h86, 1, 1, 0, 0, 0, 8'h81, 2, 0, 1);
        addRow(8'h96, 1, 1, 0, 0, 1, 8'h10, 2, 1, 1);
        addRow(8'hB6, 1, 1, 0, 0, 0, 8'h10, 2, 1, 1);
        addRow(8'hB6, 0, 1, 0, 0, 0, 8'h10, 2, 1, 1);
        addRow(8'hB7, 1, 0, 0, 0, 0, 8'h10, 2, 1, 1);
        addRow(8'hB5, 1, 0, 0, 0, 0, 8'h10, 2, 1, 1);
        addRow(8'hB5, 1, 1, 1, 0, 0, 8'h00, 0, 0, 0);
        addRow(8'hB5, 0, 1, 0, 0, 0, 8'h00, 0, 0, 0);

        modelReset();
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset", 0, 0, 8'h00, 0, 0, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;

        for (int k = 0; k < vecs.size(); k++) begin
            applyStimulus(vecs[k].inV, vecs[k].str, vecs[k].en, vecs[k].clr);
            checkOutput($sformatf("table[%0d]", k), vecs[k].eSv, vecs[k].eHv, vecs[k].eBits,
                        vecs[k].eSc, vecs[k].eHc, vecs[k].eSt);
        end

        // Five setup violations on coincident edges; the fifth carries a clr.
        applyStimulus(inSig, 0, 1, 1);
        checkModel("satClr");
        for (int k = 0; k < 6; k++) applyStimulus(inSig, 0, 1, 0);
        for (int k = 1; k <= 5; k++) begin
            applyStimulus(inSig, 0, 1, 0);
            checkModel($sformatf("satLow[%0d]", k));
            applyStimulus(inSig ^ 8'h01, 1, 1, (k == 5));
            checkOutput($sformatf("satEdge[%0d]", k), 1, 0, (k == 5) ? 8'h00 : 8'h01,
                        (k == 5) ? 0 : k, 0, (k == 5) ? 1'b0 : 1'b1);
        end

        for (int n = 0; n < 600; n++) begin
            mask = '0;
            for (int i = 0; i < W; i++) mask[i] = ($urandom_range(0, 7) == 0);
            str = ($urandom_range(0, 2) == 0) ? ~strobeSig : strobeSig;
            applyStimulus(inSig ^ mask, str, ($urandom_range(0, 9) != 0),
                          ($urandom_range(0, 49) == 0));
            checkModel($sformatf("rand[%0d]", n));
        end

        // Asynchronous reset right after a coincident violation, then re-prime with 0xFF.
        applyStimulus(inSig, 0, 1, 0);
        applyStimulus(inSig ^ 8'h81, 1, 1, 0);
        checkModel("preReset");
        #2;
        rst = 1'b1;
        #1;
        checkOutput("rstAsync", 0, 0, 8'h00, 0, 0, 0);
        modelReset();
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        applyStimulus(8'hFF, 1, 1, 0);
        checkOutput("primeCycle", 0, 0, 8'h00, 0, 0, 0);
        applyStimulus(8'hFF, 1, 1, 0);
        checkOutput("postPrime", 0, 0, 8'h00, 0, 0, 0);
        applyStimulus(8'hFF, 0, 1, 0);
        checkOutput("postPrimeLow", 0, 0, 8'h00, 0, 0, 0);
        applyStimulus(8'hFF, 1, 1, 0);
        checkOutput("postPrimeEdge", 0, 0, 8'h00, 0, 0, 0);
        applyStimulus(8'hFF, 0, 1, 0);
        checkModel("postPrimeModel");

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
